// File: rtl/gray_rd_arbiter.sv
// Two-requester read arbiter for the gray image memory: round-robin grants,
// lockable bursts capped at 16 grants, and one-cycle-registered read-data return.
module gray_rd_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [13:0] addr0,
    input  logic [13:0] addr1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [7:0]  rdata0,
    output logic [7:0]  rdata1,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [13:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        busy
);

    typedef enum logic [1:0] {WAIT_RDY, ARB, BURST0, BURST1} state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;    // requester that wins the next contention
    logic [3:0]  cnt_q, cnt_d;
    logic        rvalid0_q, rvalid1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_RDY;
            prio_q    <= 1'b0;
            cnt_q     <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        if (gnt0)
            prio_d = 1'b1;
        else if (gnt1)
            prio_d = 1'b0;
        unique case (state_q)
            WAIT_RDY: begin
                if (mem_ready)
                    state_d = ARB;
            end
            ARB: begin
                if (gnt0 && lock0) begin
                    state_d = BURST0;
                    cnt_d   = 4'd1;
                end else if (gnt1 && lock1) begin
                    state_d = BURST1;
                    cnt_d   = 4'd1;
                end
            end
            BURST0: begin
                if (gnt0) begin
                    cnt_d = cnt_q + 4'd1;
                    // 16th consecutive grant: yield to a waiting requester
                    if (cnt_q == 4'hF && req1) begin
                        state_d = ARB;
                        cnt_d   = 4'd0;
                    end
                end else if (gnt1 && lock1) begin
                    state_d = BURST1;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = ARB;
                    cnt_d   = 4'd0;
                end
            end
            BURST1: begin
                if (gnt1) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'hF && req0) begin
                        state_d = ARB;
                        cnt_d   = 4'd0;
                    end
                end else if (gnt0 && lock0) begin
                    state_d = BURST0;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = ARB;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = WAIT_RDY;
        endcase
    end

    // Leaving a burst, the other requester may be granted in the same cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            ARB: begin
                if (req0 && req1) begin
                    gnt0 = ~prio_q;
                    gnt1 = prio_q;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
            BURST0: begin
                if (req0 && lock0) gnt0 = 1'b1;
                else               gnt1 = req1;
            end
            BURST1: begin
                if (req1 && lock1) gnt1 = 1'b1;
                else               gnt0 = req0;
            end
            default: ;
        endcase
        mem_req  = gnt0 | gnt1;
        mem_addr = gnt0 ? addr0 : (gnt1 ? addr1 : 14'd0);
        busy     = (state_q == BURST0) || (state_q == BURST1);
        rvalid0  = rvalid0_q;
        rvalid1  = rvalid1_q;
        rdata0   = rvalid0_q ? mem_data : 8'd0;
        rdata1   = rvalid1_q ? mem_data : 8'd0;
    end

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Randomized and directed bench for gray_rd_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_gray_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, lock0, lock1, mem_ready;
    logic [13:0] addr0, addr1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_req, busy;
    logic [7:0]  rdata0, rdata1, mem_data;
    logic [13:0] mem_addr;

    int n_vec = 0;
    int n_err = 0;

    gray_rd_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [13:0] a);
        logic [13:0] t;
        t = a ^ (a >> 6);
        return t[7:0] + 8'h35;
    endfunction

    // Memory with one-cycle read latency; junk on idle cycles.
    always @(posedge clk) begin
        if (mem_req) mem_data <= memf(mem_addr);
        else         mem_data <= 8'hA5;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: mode 0 = waiting for memory, 1 = arbitrate, 2 = burst owned by m_owner.
    int          m_mode, m_owner, m_prio, m_run;
    bit          m_rv[2];
    logic [13:0] m_raddr[2];
    logic        obs_g0, obs_g1, obs_busy;

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_prio = 0; m_run = 0;
        m_rv[0] = 0; m_rv[1] = 0; m_raddr[0] = '0; m_raddr[1] = '0;
    endtask

    task automatic step(input bit r0, input bit r1, input bit l0, input bit l1,
                        input bit mr, input logic [13:0] a0, input logic [13:0] a1);
        bit          rq[2], lk[2], eg[2];
        logic [13:0] ad[2], ea;
        int          w;
        req0 = r0; req1 = r1; lock0 = l0; lock1 = l1; mem_ready = mr;
        addr0 = a0; addr1 = a1;
        rq[0] = r0; rq[1] = r1; lk[0] = l0; lk[1] = l1; ad[0] = a0; ad[1] = a1;
        eg[0] = 0; eg[1] = 0;
        #1;
        if (m_mode == 1) begin
            if (r0 && r1) eg[m_prio] = 1;
            else begin eg[0] = r0; eg[1] = r1; end
        end else if (m_mode == 2) begin
            if (rq[m_owner] && lk[m_owner]) eg[m_owner] = 1;
            else eg[1 - m_owner] = rq[1 - m_owner];
        end
        ea = eg[0] ? a0 : (eg[1] ? a1 : 14'd0);
        chk("gnt0", gnt0, eg[0]);
        chk("gnt1", gnt1, eg[1]);
        chk("mem_req", mem_req, eg[0] | eg[1]);
        chk("mem_addr", mem_addr, ea);
        chk("busy", busy, m_mode == 2);
        chk("rvalid0", rvalid0, m_rv[0]);
        chk("rvalid1", rvalid1, m_rv[1]);
        chk("rdata0", rdata0, m_rv[0] ? memf(m_raddr[0]) : 8'd0);
        chk("rdata1", rdata1, m_rv[1] ? memf(m_raddr[1]) : 8'd0);
        obs_g0 = gnt0; obs_g1 = gnt1; obs_busy = busy;
        @(posedge clk); #1;
        for (int x = 0; x < 2; x++) begin
            m_rv[x] = eg[x];
            if (eg[x]) m_raddr[x] = ad[x];
        end
        w = eg[0] ? 0 : (eg[1] ? 1 : -1);
        case (m_mode)
            0: if (mr) m_mode = 1;
            1: if (w >= 0 && lk[w]) begin m_mode = 2; m_owner = w; m_run = 1; end
            default: begin
                if (w == m_owner) begin
                    m_run++;
                    if (m_run % 16 == 0 && rq[1 - m_owner]) m_mode = 1;
                end else begin
                    m_mode = 1;
                    if (w >= 0 && lk[w]) begin m_mode = 2; m_owner = w; m_run = 1; end
                end
            end
        endcase
        if (w >= 0) m_prio = 1 - w;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 14'd0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    int first_g, cnt, run, maxrun;
    logic [13:0] blist[9] = '{14'd0, 14'd1, 14'd2, 14'd128, 14'd129, 14'd130,
                              14'd256, 14'd257, 14'd258};

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; mem_ready = 0;
        addr0 = '0; addr1 = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Start-up: no grant while memory not ready, then grant of address 129.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 14'd129, 14'd0);
        first_g = -1;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 1, 14'd129, 14'd0);
            if (obs_g0 && first_g < 0) first_g = i;
        end
        chk("first_gnt_cycle", first_g, 1);
        step(0, 0, 0, 0, 0, 14'd0, 14'd0);
        step(0, 0, 0, 0, 0, 14'd0, 14'd0);

        // Contention without lock.
        for (int i = 0; i < 8; i++)
            step(1, 1, 0, 0, 0, 14'($urandom), 14'($urandom));

        // Nine-pixel window burst by requester 0 while requester 1 waits.
        step(0, 1, 0, 0, 1, 14'd0, 14'd77);
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 1, 0, 1, blist[i], 14'd77);
            if (obs_g0) cnt++;
        end
        chk("burst_gnt0_count", cnt, 9);
        chk("burst_busy_end", obs_busy, 1'b1);
        step(0, 1, 0, 0, 1, 14'd0, 14'd78);
        chk("burst_release_gnt1", obs_g1, 1'b1);
        step(0, 0, 0, 0, 1, 14'd0, 14'd0);

        // Starvation limit on a requester-1 burst.
        run = 0; maxrun = 0;
        for (int i = 0; i < 24; i++) begin
            step(1, 1, 0, 1, 1, 14'($urandom), 14'($urandom));
            if (obs_g1) run++; else run = 0;
            if (run > maxrun) maxrun = run;
        end
        chk("starve_max_run", maxrun, 16);
        step(0, 0, 0, 0, 1, 14'd0, 14'd0);

        // Reset in the middle of a requester-0 burst.
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 1, 14'(i + 300), 14'd9);
        chk("pre_reset_busy", obs_busy, 1'b1);
        do_reset();
        step(1, 1, 0, 0, 0, 14'd11, 14'd22);
        step(1, 1, 0, 0, 1, 14'd11, 14'd22);
        step(1, 1, 0, 0, 1, 14'd11, 14'd22);
        chk("post_reset_prio0", obs_g0, 1'b1);
        step(0, 0, 0, 0, 1, 14'd0, 14'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 3) != 0), 14'($urandom), 14'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
